// File: rtl/lcd_rom_writer.sv
// HD44780 8-bit LCD refresher: power-on delay, init commands, then rewrites all
// 32 characters from a registered character ROM on each start request.
module lcd_rom_writer #(
  parameter int POWERON_CYC    = 1_000_000,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [4:0] romAddr,
  input  logic [7:0] romData,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);

  localparam int MAX_A   = (POWERON_CYC > E_PULSE_CYC) ? POWERON_CYC : E_PULSE_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] POWERON_LAST = CNT_W'(POWERON_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_POWERON, S_INIT, S_IDLE, S_LINE_CMD, S_FETCH, S_WRITE, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  state_t           r_state,    w_state_nxt;
  phase_t           r_phase,    w_phase_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic [1:0]       r_init_idx, w_init_idx_nxt;
  logic [4:0]       r_addr,     w_addr_nxt;
  logic [7:0]       r_char,     w_char_nxt;
  logic             r_pending,  w_pending_nxt;

  logic             w_in_byte;
  logic             w_byte_end;
  logic             w_rs;
  logic [7:0]       w_byte;
  logic [CNT_W-1:0] w_wait_last;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_POWERON;
      r_phase    <= PH_SETUP;
      r_cnt      <= '0;
      r_init_idx <= '0;
      r_addr     <= '0;
      r_char     <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_cnt      <= w_cnt_nxt;
      r_init_idx <= w_init_idx_nxt;
      r_addr     <= w_addr_nxt;
      r_char     <= w_char_nxt;
      r_pending  <= w_pending_nxt;
    end
  end

  assign w_in_byte   = (r_state == S_INIT) || (r_state == S_LINE_CMD) || (r_state == S_WRITE);
  assign w_wait_last = (!w_rs && w_byte == 8'h01) ? CLEAR_LAST : CMD_LAST;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_cnt_nxt      = r_cnt;
    w_init_idx_nxt = r_init_idx;
    w_addr_nxt     = r_addr;
    w_char_nxt     = r_char;
    w_pending_nxt  = r_pending;
    w_byte_end     = 1'b0;

    // Per-byte timing: one setup cycle, enable pulse, then the settle wait.
    if (w_in_byte) begin
      unique case (r_phase)
        PH_SETUP: begin
          w_phase_nxt = PH_PULSE;
          w_cnt_nxt   = '0;
        end
        PH_PULSE: begin
          if (r_cnt == PULSE_LAST) begin
            w_phase_nxt = PH_WAIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        PH_WAIT: begin
          if (r_cnt == w_wait_last) begin
            w_byte_end  = 1'b1;
            w_phase_nxt = PH_SETUP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: w_phase_nxt = PH_SETUP;
      endcase
    end

    unique case (r_state)
      S_POWERON: begin
        w_pending_nxt = r_pending | start;
        if (r_cnt == POWERON_LAST) begin
          w_state_nxt    = S_INIT;
          w_phase_nxt    = PH_SETUP;
          w_cnt_nxt      = '0;
          w_init_idx_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_INIT: begin
        w_pending_nxt = r_pending | start;
        if (w_byte_end) begin
          if (r_init_idx == 2'd3) w_state_nxt = S_IDLE;
          else                    w_init_idx_nxt = r_init_idx + 2'd1;
        end
      end
      S_IDLE: begin
        if (start || r_pending) begin
          w_state_nxt   = S_LINE_CMD;
          w_addr_nxt    = '0;
          w_pending_nxt = 1'b0;
          w_phase_nxt   = PH_SETUP;
          w_cnt_nxt     = '0;
        end
      end
      S_LINE_CMD: begin
        if (w_byte_end) w_state_nxt = S_FETCH;
      end
      // The ROM output is registered: capture on the second edge after romAddr settles.
      S_FETCH: begin
        if (r_cnt == FETCH_LAST) begin
          w_char_nxt  = romData;
          w_state_nxt = S_WRITE;
          w_phase_nxt = PH_SETUP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (w_byte_end) begin
          if (r_addr == 5'd31) begin
            w_state_nxt = S_DONE;
          end else begin
            w_addr_nxt  = r_addr + 5'd1;
            w_state_nxt = (r_addr == 5'd15) ? S_LINE_CMD : S_FETCH;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_POWERON;
    endcase
  end

  // The line-address command follows romAddr bit 4: 0x80 for line 1, 0xC0 for line 2.
  always_comb begin
    w_byte = 8'h00;
    w_rs   = 1'b0;
    unique case (r_state)
      S_INIT:     w_byte = init_cmd(r_init_idx);
      S_LINE_CMD: w_byte = r_addr[4] ? 8'hC0 : 8'h80;
      S_WRITE: begin
        w_byte = r_char;
        w_rs   = 1'b1;
      end
      default: ;
    endcase
    lcd_data = w_byte;
    lcd_rs   = w_rs;
    lcd_rw   = 1'b0;
    lcd_en   = w_in_byte && (r_phase == PH_PULSE);
    romAddr  = r_addr;
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_lcd_rom_writer.sv
// Self-checking bench for lcd_rom_writer: a negedge monitor collects every enable
// pulse, and the stimulus compares them with tables and a ROM-driven reference.
module tb_lcd_rom_writer;

  localparam int P_ON  = 10;
  localparam int P_E   = 2;
  localparam int P_CMD = 3;
  localparam int P_CLR = 8;

  logic       clk, reset, start;
  logic [4:0] romAddr;
  logic [7:0] romData;
  logic       lcd_rs, lcd_rw, lcd_en, busy, done;
  logic [7:0] lcd_data;

  lcd_rom_writer #(
    .POWERON_CYC(P_ON), .E_PULSE_CYC(P_E), .CMD_WAIT_CYC(P_CMD), .CLEAR_WAIT_CYC(P_CLR)
  ) dut (
    .clock(clk), .reset(reset), .start(start), .romAddr(romAddr), .romData(romData),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] rom_mem [32];
  always @(posedge clk) romData <= rom_mem[romAddr];

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] addr;
    int         width;
    int         gap;
    bit         stable;
  } pulse_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         width;
    int         gap;
  } init_vec_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] addr;
  } exp_t;

  function automatic int exp_wait(input logic rs, input logic [7:0] d);
    return (!rs && d == 8'h01) ? P_CLR : P_CMD;
  endfunction

  // Monitor state is written only here; the stimulus requests a clear by bumping clr_gen.
  int     clr_gen = 0;
  int     mon_gen = 0;
  pulse_t pq[$];
  pulse_t cur;
  bit     open_p;
  int     rises, dones, idles, samples, first_rise;
  logic   prev_en, prev_rs;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (mon_gen != clr_gen) begin
      mon_gen = clr_gen;
      pq.delete();
      open_p = 0; rises = 0; dones = 0; idles = 0; samples = 0; first_rise = 0;
    end
    if (reset) begin
      open_p = 0;
    end else begin
      samples++;
      if (lcd_en && !prev_en) begin
        if (open_p) pq.push_back(cur);
        cur.rs     = lcd_rs;
        cur.data   = lcd_data;
        cur.addr   = romAddr;
        cur.width  = 1;
        cur.gap    = 0;
        cur.stable = (prev_rs == lcd_rs) && (prev_data == lcd_data);
        open_p     = 1;
        rises++;
        if (first_rise == 0) first_rise = samples;
      end else if (open_p) begin
        if (!busy) begin
          pq.push_back(cur);
          open_p = 0;
        end else begin
          if (lcd_en) cur.width++;
          else        cur.gap++;
          if (lcd_en || cur.gap <= exp_wait(cur.rs, cur.data))
            cur.stable &= (lcd_rs == cur.rs) && (lcd_data == cur.data);
        end
      end
      if (done)  dones++;
      if (!busy) idles++;
    end
    prev_en   = lcd_en;
    prev_rs   = lcd_rs;
    prev_data = lcd_data;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr_gen++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    check("reset romAddr",  romAddr,  0);
    check("reset lcd_rs",   lcd_rs,   0);
    check("reset lcd_rw",   lcd_rw,   0);
    check("reset lcd_en",   lcd_en,   0);
    check("reset lcd_data", lcd_data, 8'h00);
    check("reset busy",     busy,     1);
    check("reset done",     done,     0);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      tick(1);
      n++;
    end
    check({tag, " reached idle in time"}, (n < max), 1);
    tick(2);
  endtask

  task automatic wait_dones(input string tag, input int target, input int max);
    int n = 0;
    while (dones < target && n < max) begin
      tick(1);
      n++;
    end
    check({tag, " done seen in time"}, (n < max), 1);
  endtask

  task automatic wait_rises(input int target, input int max);
    int n = 0;
    while (rises < target && n < max) begin
      tick(1);
      n++;
    end
    check("rise target reached", (n < max), 1);
  endtask

  init_vec_t init_tbl[4];

  task automatic check_init(input string tag);
    check({tag, " first enable after power-on quiet + setup"}, first_rise, P_ON + 2);
    check({tag, " init pulse count"}, (pq.size() >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      if (i >= pq.size()) break;
      check($sformatf("%s init[%0d] rs",     tag, i), pq[i].rs,     init_tbl[i].rs);
      check($sformatf("%s init[%0d] data",   tag, i), pq[i].data,   init_tbl[i].data);
      check($sformatf("%s init[%0d] width",  tag, i), pq[i].width,  init_tbl[i].width);
      check($sformatf("%s init[%0d] gap",    tag, i), pq[i].gap,    init_tbl[i].gap);
      check($sformatf("%s init[%0d] stable", tag, i), pq[i].stable, 1);
    end
  endtask

  // Reference: one refresh is the line-1 command, ROM 0..15, line-2 command, ROM 16..31.
  task automatic check_refresh(input string tag, input int base);
    exp_t e[$];
    e.push_back('{1'b0, 8'h80, 5'd0});
    for (int i = 0; i < 16; i++) e.push_back('{1'b1, rom_mem[i], 5'(i)});
    e.push_back('{1'b0, 8'hC0, 5'd0});
    for (int i = 16; i < 32; i++) e.push_back('{1'b1, rom_mem[i], 5'(i)});
    check({tag, " total pulses"}, pq.size(), base + 34);
    for (int i = 0; i < 34; i++) begin
      if (base + i >= pq.size()) break;
      check($sformatf("%s[%0d] rs",     tag, i), pq[base+i].rs,     e[i].rs);
      check($sformatf("%s[%0d] data",   tag, i), pq[base+i].data,   e[i].data);
      check($sformatf("%s[%0d] width",  tag, i), pq[base+i].width,  P_E);
      check($sformatf("%s[%0d] stable", tag, i), pq[base+i].stable, 1);
      if (e[i].rs)
        check($sformatf("%s[%0d] romAddr", tag, i), pq[base+i].addr, e[i].addr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    int    idle_snap;
    reset = 1'b1;
    start = 1'b0;
    s = "DEFINIR SECUN:  P:XY  S:XY  A:XY";
    for (int i = 0; i < 32; i++) rom_mem[i] = s[i];

    init_tbl[0] = '{1'b0, 8'h38, P_E, P_CMD + 1};
    init_tbl[1] = '{1'b0, 8'h0C, P_E, P_CMD + 1};
    init_tbl[2] = '{1'b0, 8'h06, P_E, P_CMD + 1};
    init_tbl[3] = '{1'b0, 8'h01, P_E, P_CLR};

    // Power-on and init with no start.
    do_reset();
    wait_idle("poweron", 500);
    check_init("poweron");
    check("poweron pulses only init", pq.size(), 4);
    check("poweron no done", dones, 0);

    // Refresh with the fixed display text.
    clear_mon();
    pulse_start();
    wait_dones("text", 1, 3000);
    tick(20);
    check_refresh("text", 0);
    check("text done count", dones, 1);
    check("text busy low after", busy, 0);

    // Randomized ROM contents against the reference.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) rom_mem[i] = 8'($urandom_range(32, 126));
      clear_mon();
      tick(1);
      pulse_start();
      wait_dones($sformatf("rand%0d", r), 1, 3000);
      tick(20);
      check_refresh($sformatf("rand%0d", r), 0);
      check($sformatf("rand%0d done count", r), dones, 1);
    end

    // Start during character 5 is ignored and not remembered.
    clear_mon();
    tick(1);
    pulse_start();
    wait_rises(7, 1000);
    check("mid-refresh still writing char", lcd_rs, 1);
    pulse_start();
    wait_dones("midstart", 1, 3000);
    tick(60);
    check_refresh("midstart", 0);
    check("midstart done count", dones, 1);
    check("midstart rises", rises, 34);
    check("midstart busy low", busy, 0);

    // Start during power-on is held until init completes.
    s = "DEFINIR SECUN:  P:XY  S:XY  A:XY";
    for (int i = 0; i < 32; i++) rom_mem[i] = s[i];
    do_reset();
    tick(3);
    pulse_start();
    wait_dones("pending", 1, 3000);
    idle_snap = idles;
    tick(20);
    check_init("pending");
    check("pending single idle cycle before refresh", idle_snap, 1);
    check_refresh("pending", 4);
    check("pending done count", dones, 1);

    // Reset in the middle of a character enable pulse.
    clear_mon();
    tick(1);
    pulse_start();
    wait_rises(4, 1000);
    check("pre-reset enable high", lcd_en, 1);
    reset = 1'b1;
    tick(1);
    check("midreset lcd_en dropped", lcd_en, 0);
    check("midreset busy",          busy,   1);
    check("midreset romAddr",       romAddr, 0);
    reset = 1'b0;
    clear_mon();
    wait_idle("midreset", 500);
    check_init("midreset");
    check("midreset pulses only init", pq.size(), 4);
    check("midreset no done", dones, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_rom_writer.md
LCD_ROM_WRITER -- requirements
Module: lcd_rom_writer

Interface
REQ-001 SHALL have parameter POWERON_CYC, 1_000_000, idle cycles after reset before the first LCD command (20 ms at 50 MHz).
REQ-002 SHALL have parameter E_PULSE_CYC, 25, cycles lcd_en is held high per byte (500 ns).
REQ-003 SHALL have parameter CMD_WAIT_CYC, 2500, cycles waited after lcd_en falls for an ordinary byte (50 us).
REQ-004 SHALL have parameter CLEAR_WAIT_CYC, 100_000, cycles waited after lcd_en falls for the clear command 0x01 (2 ms).
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clock  input  1  system clock; all state changes on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to rewrite the full 32-character display.
REQ-009 romAddr  output  5  character ROM address, 0..31.
REQ-010 romData  input  8  ASCII byte from the character ROM, registered: valid on the second rising edge after romAddr changes.
REQ-011 lcd_rs  output  1  0 = command, 1 = character data.
REQ-012 lcd_rw  output  1  constant 0 (write only).
REQ-013 lcd_en  output  1  HD44780 enable strobe.
REQ-014 lcd_data  output  8  8-bit LCD data bus.
REQ-015 busy  output  1  high whenever the block is not in IDLE.
REQ-016 done  output  1  one-cycle pulse when a refresh completes.

Function
REQ-017 SHALL implement states POWERON, INIT, IDLE, LINE_CMD, FETCH, WRITE, and DONE.
REQ-018 POWERON SHALL count POWERON_CYC cycles with lcd_en=0, then enter INIT.
REQ-019 INIT SHALL issue commands 0x38, 0x0C, 0x06, 0x01 in that order with lcd_rs=0, then enter IDLE.
REQ-020 Every byte write SHALL follow this sequence:
  - cycle 0: drive lcd_rs and lcd_data with lcd_en=0 (1 setup cycle);
  - lcd_en=1 for exactly E_PULSE_CYC cycles;
  - lcd_en=0 for CMD_WAIT_CYC cycles, or CLEAR_WAIT_CYC when the byte is command 0x01;
  - lcd_rs and lcd_data SHALL stay stable from setup through the end of the wait.
REQ-021 In IDLE, start=1 SHALL begin a refresh: command 0x80, characters at ROM addresses 0..15, command 0xC0, characters at ROM addresses 16..31, then DONE.
REQ-022 FETCH SHALL drive romAddr, wait one cycle, and capture romData on the following edge into the byte sent by WRITE with lcd_rs=1; romAddr SHALL be held until the capture.
REQ-023 After the write for address 15 the block SHALL issue 0xC0 before fetching address 16; after address 31 it SHALL enter DONE without wrapping romAddr.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 busy SHALL be 0 only in IDLE; done and busy SHALL never both be 1 with the FSM in IDLE.
REQ-026 A start pulse during POWERON or INIT SHALL be latched as pending; the refresh SHALL begin on the first cycle in IDLE.
REQ-027 A start pulse during a refresh (LINE_CMD, FETCH, WRITE, DONE) SHALL be ignored, with no pending request retained.
REQ-028 All delay counters SHALL be wide enough for the largest parameter value and SHALL saturate/reset per byte with no wrap-around between bytes.

Reset
REQ-029 On reset=1 at a rising edge the block SHALL set state POWERON, all counters 0, and the pending flag 0.
REQ-030 The reset values of the outputs SHALL be: romAddr=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=0x00, busy=1, done=0.
REQ-031 Reset asserted mid-write SHALL drop lcd_en to 0 on that edge and restart the full power-on and init sequence.

Verification (POWERON_CYC=10, E_PULSE_CYC=2, CMD_WAIT_CYC=3, CLEAR_WAIT_CYC=8)
REQ-032 Reset, then idle -> bench SHALL see:
  - no lcd_en activity for 10 cycles;
  - four lcd_en pulses, each 2 cycles wide, latching 0x38, 0x0C, 0x06, 0x01 with rs=0;
  - 8-cycle wait after 0x01;
  - busy falls.
REQ-033 With the ROM model loaded "DEFINIR SECUN:  P:XY  S:XY  A:XY", start in IDLE -> bench SHALL see:
  - 34 pulses in order: 0x80, then 16 rs=1 bytes "DEFINIR SECUN:  ", then 0xC0, then "P:XY  S:XY  A:XY";
  - done high for 1 cycle;
  - busy low.
REQ-034 For each character byte -> bench SHALL see lcd_data equal to the ROM content at the romAddr presented two edges earlier.
REQ-035 start pulsed during POWERON -> bench SHALL see the refresh begin immediately after init with no further start.
REQ-036 start pulsed during character 5 -> bench SHALL see the total pulse count unchanged (34) and exactly one done.
REQ-037 reset asserted while lcd_en=1 during a character write -> bench SHALL see lcd_en=0 on the next edge, busy=1, and a complete init replayed before IDLE.
